// File: rtl/led_run_module_if.sv
// Control and LED-drive bundle for the LED pattern generator.
// The master drives run/mode/timing controls; the slave returns the LED and tick outputs.
interface led_run_module_if #(
  parameter int N_LED = 4,
  parameter int CNT_W = 23
);
  logic             Enable;
  logic [1:0]       Mode;
  logic [CNT_W-1:0] Period;
  logic [CNT_W-1:0] Duty;
  logic [N_LED-1:0] LED_Out;
  logic             Step_Tick;

  modport master (output Enable, Mode, Period, Duty, input LED_Out, Step_Tick);
  modport slave  (input Enable, Mode, Period, Duty, output LED_Out, Step_Tick);
endinterface

// File: rtl/led_run_module.sv
// Multi-channel LED pattern generator: off, blink-all, running light and ping-pong,
// with a programmable step period and an in-step duty window.
module led_run_module #(
  parameter int N_LED    = 4,
  parameter int CNT_W    = 23,
  parameter int DEF_PER  = 20,
  parameter int DEF_DUTY = 10
) (
  input logic               CLK,
  input logic               RST,
  led_run_module_if.slave   bus
);
  typedef enum logic [1:0] {MODE_OFF, MODE_BLINK, MODE_RUN, MODE_PING} mode_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  localparam int               POS_W    = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LED - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [N_LED-1:0] ALL_ON   = '1;

  logic [CNT_W-1:0] count, next_count;
  logic [CNT_W-1:0] r_period, next_period;
  logic [CNT_W-1:0] r_duty, next_duty;
  mode_t            r_mode, next_mode;
  logic [POS_W-1:0] pos, next_pos;
  dir_t             dir, next_dir;
  logic [N_LED-1:0] led_out, next_led;
  logic             step_tick, next_tick;

  mode_t            in_mode;
  logic [CNT_W-1:0] in_period;
  logic             wrap;

  assign in_mode   = mode_t'(bus.Mode);
  assign in_period = (bus.Period == '0) ? CNT_W'(1) : bus.Period;
  assign wrap      = bus.Enable && (count == r_period);

  // NOTE: every next_* value gets a default before any branch so no path leaves it unassigned (no latches).
  always_comb begin
    next_count  = count;
    next_period = r_period;
    next_duty   = r_duty;
    next_mode   = r_mode;
    next_pos    = pos;
    next_dir    = dir;
    next_led    = '0;
    next_tick   = 1'b0;

    if (bus.Enable && (r_mode != MODE_OFF) && (count < r_duty))
      next_led = (r_mode == MODE_BLINK) ? ALL_ON : (N_LED'(1) << pos);

    if (!bus.Enable) begin
      next_period = in_period;
      next_duty   = bus.Duty;
      next_mode   = in_mode;
    end else if (wrap) begin
      next_count  = '0;
      next_tick   = 1'b1;
      next_period = in_period;
      next_duty   = bus.Duty;
      next_mode   = in_mode;
      case (r_mode)
        MODE_RUN:  next_pos = (pos == POS_LAST) ? '0 : pos + POS_ONE;
        MODE_PING: begin
          // Bounce at either end so a pointer inherited from another mode stays in range.
          if (N_LED > 1) begin
            if (dir == DIR_UP) begin
              if (pos == POS_LAST) begin
                next_pos = pos - POS_ONE;
                next_dir = DIR_DOWN;
              end else begin
                next_pos = pos + POS_ONE;
                if (pos + POS_ONE == POS_LAST) next_dir = DIR_DOWN;
              end
            end else begin
              if (pos == '0) begin
                next_pos = POS_ONE;
                next_dir = DIR_UP;
              end else begin
                next_pos = pos - POS_ONE;
                if (pos == POS_ONE) next_dir = DIR_UP;
              end
            end
          end
        end
        default: next_pos = pos;
      endcase
      if (in_mode != r_mode) begin
        next_pos = '0;
        next_dir = DIR_UP;
      end
    end else begin
      next_count = count + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count     <= '0;
      r_period  <= CNT_W'(DEF_PER);
      r_duty    <= CNT_W'(DEF_DUTY);
      r_mode    <= MODE_OFF;
      pos       <= '0;
      dir       <= DIR_UP;
      led_out   <= '0;
      step_tick <= 1'b0;
    end else begin
      count     <= next_count;
      r_period  <= next_period;
      r_duty    <= next_duty;
      r_mode    <= next_mode;
      pos       <= next_pos;
      dir       <= next_dir;
      led_out   <= next_led;
      step_tick <= next_tick;
    end
  end

  assign bus.LED_Out   = led_out;
  assign bus.Step_Tick = step_tick;
endmodule

// File: tb/tb_led_run_module.sv
// Randomized and directed bench for led_run_module against a step-level reference model.
module tb_led_run_module;
  localparam int N_LED    = 4;
  localparam int CNT_W    = 23;
  localparam int DEF_PER  = 20;
  localparam int DEF_DUTY = 10;
  localparam int ALL_ON   = (1 << N_LED) - 1;

  logic CLK = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_errors = 0;

  led_run_module_if #(.N_LED(N_LED), .CNT_W(CNT_W)) bus ();

  led_run_module #(
    .N_LED(N_LED), .CNT_W(CNT_W), .DEF_PER(DEF_PER), .DEF_DUTY(DEF_DUTY)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: step position kept as an index on a ping-pong ring of length 2N-2.
  int m_count, m_per, m_duty, m_mode, m_pos;
  bit m_down;
  int exp_led;
  bit exp_tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_advance();
    int ring, t;
    if (m_mode == 2) m_pos = (m_pos + 1) % N_LED;
    else if (m_mode == 3 && N_LED > 1) begin
      ring   = 2 * N_LED - 2;
      t      = m_down ? (ring - m_pos) % ring : m_pos;
      t      = (t + 1) % ring;
      m_pos  = (t < N_LED) ? t : ring - t;
      m_down = (t >= N_LED - 1);
    end
  endtask

  task automatic model_edge();
    bit wrap;
    if (RST) begin
      m_count = 0; m_pos = 0; m_down = 0; m_mode = 0;
      m_per = DEF_PER; m_duty = DEF_DUTY;
      exp_led = 0; exp_tick = 0;
      return;
    end
    exp_led = 0;
    if (bus.Enable && m_mode != 0 && m_count < m_duty)
      exp_led = (m_mode == 1) ? ALL_ON : (1 << m_pos);
    wrap     = bus.Enable && (m_count == m_per);
    exp_tick = wrap;
    if (bus.Enable) begin
      if (wrap) begin
        m_count = 0;
        model_advance();
        if (int'(bus.Mode) != m_mode) begin
          m_pos = 0; m_down = 0;
        end
      end else m_count++;
    end
    if (!bus.Enable || wrap) begin
      m_mode = int'(bus.Mode);
      m_per  = (bus.Period == 0) ? 1 : int'(bus.Period);
      m_duty = int'(bus.Duty);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_edge();
    #1;
    check("led", 32'(bus.LED_Out), 32'(exp_led));
    check("tick", 32'(bus.Step_Tick), 32'(exp_tick));
  endtask

  task automatic set_in(input bit en, input int mode, input int per, input int duty);
    bus.Enable = en;
    bus.Mode   = 2'(mode);
    bus.Period = CNT_W'(per);
    bus.Duty   = CNT_W'(duty);
  endtask

  task automatic wait_tick(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc();
      seen = bus.Step_Tick;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    bit found;
    int seq[9] = '{0, 1, 2, 3, 2, 1, 0, 1, 2};

    // Reset with arbitrary inputs, then idle with Enable low.
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in($urandom_range(1), $urandom_range(3), $urandom_range(9), $urandom_range(9));
      cyc();
    end
    RST = 1'b0;
    set_in(0, 2, 3, 2);
    for (int i = 0; i < 4; i++) cyc();

    // Running light: dark reset-mode step, then 4-cycle steps.
    bus.Enable = 1'b1;
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    for (int i = 0; i < DEF_PER; i++) cyc();
    cyc();
    check("t2_first_tick", 32'(bus.Step_Tick), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("t2_led", 32'(bus.LED_Out), (i % 4 < 2) ? 32'(1 << ((i / 4) % 4)) : 32'd0);
      check("t2_tick", 32'(bus.Step_Tick), 32'(i % 4 == 3));
    end

    // Ping-pong with 2-cycle steps, duty covers the whole step.
    set_in(1, 3, 1, 2);
    wait_tick("t3_wait", 10);
    for (int i = 0; i < 18; i++) begin
      cyc();
      check("t3_led", 32'(bus.LED_Out), 32'(1 << seq[i / 2]));
    end

    // Mid-step change is deferred until the wrap of the current step.
    set_in(1, 2, 3, 2);
    wait_tick("t4_wait", 10);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      found = (m_count == 1);
      if (!found) cyc();
    end
    check("t4_sync", 32'(found), 32'd1);
    set_in(1, 1, 7, 2);
    cyc(); check("t4_no_early_a", 32'(bus.Step_Tick), 32'd0);
    cyc(); check("t4_no_early_b", 32'(bus.Step_Tick), 32'd0);
    cyc(); check("t4_wrap_old", 32'(bus.Step_Tick), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("t4_blink", 32'(bus.LED_Out), (i < 2) ? 32'(ALL_ON) : 32'd0);
      check("t4_len", 32'(bus.Step_Tick), 32'(i == 7));
    end

    // Duty extremes and a zero period.
    set_in(1, 2, 3, 0);
    for (int i = 0; i < 20; i++) cyc();
    set_in(1, 2, 3, 4);
    wait_tick("t5_wait", 20);
    wait_tick("t5_wait2", 20);
    for (int i = 0; i < 12; i++) begin
      cyc();
      check("t5_lit", 32'(|bus.LED_Out), 32'd1);
    end
    set_in(1, 2, 0, 1);
    for (int i = 0; i < 16; i++) cyc();

    // Reset in the middle of a step.
    set_in(1, 2, 3, 2);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      found = (m_count == 2 && m_pos == 2 && m_mode == 2);
      if (!found) cyc();
    end
    check("t6_sync", 32'(found), 32'd1);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    for (int i = 0; i < 30; i++) cyc();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0)
        set_in($urandom_range(7) != 0, $urandom_range(3), $urandom_range(6), $urandom_range(8));
      else if ($urandom_range(15) == 0)
        bus.Enable = ~bus.Enable;
      RST = ($urandom_range(199) == 0);
      cyc();
    end
    RST = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
